uart_tx_dma_burst: RTL and testbench

//  Fetches a block of bytes from a synchronous byte memory (base address + length) and

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_dma_burst_if.sv | 23 ++
 rtl/uart_tx_dma_burst_serializer.sv | 103 ++++++++++
 rtl/uart_tx_dma_burst.sv | 130 +++++++++++++
 tb/tb_uart_tx_dma_burst.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// UART / DMA shared types and helpers.
// Parity modes, DMA state encoding and the baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    SEND,
    FIN
  } dma_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int uart_div(input int clock, input int baud);
    return (clock + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_dma_burst_if.sv
// Synchronous byte-memory read port.
// Read data is valid exactly one cycle after rd_en.
interface uart_tx_dma_burst_if #(
  parameter int AddrW = 16
) ();

  logic             rd_en;
  logic [AddrW-1:0] rd_addr;
  logic [7:0]       rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/uart_tx_dma_burst_serializer.sv
// UART frame serializer: start, 8 data LSB first, parity, stop bits.
// Holds the baud and bit counters; frame_done marks the last cycle.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int Clock  = 50000000,
  parameter int Baud   = 9600,
  parameter int Stop   = 1,
  parameter int Parity = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       frame_done,
  output logic       ready
);

  localparam int DIV = uart_div(Clock, Baud);
  localparam int CW  = $clog2(DIV + 1);
  localparam int NB  = 9 + Stop + ((Parity != 0) ? 1 : 0);
  localparam parity_t PMODE = (Parity == 2) ? PAR_ODD :
                              ((Parity == 1) ? PAR_EVEN : PAR_NONE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [NB-1:0] sh_q, sh_d;
  logic [NB-1:0] frame;
  logic          txd_q, txd_d;
  logic          act_q, act_d;
  logic          par;
  logic          tick;
  logic          last;

  // Parity bit and the full frame image, bit 0 sent first.
  always_comb begin
    par = 1'b0;
    unique case (PMODE)
      PAR_EVEN: par = ^data;
      PAR_ODD:  par = ~^data;
      default:  par = 1'b0;
    endcase
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = data;
    if (PMODE != PAR_NONE) frame[9] = par;
  end

  assign tick       = act_q && (cnt_q == CW'(DIV - 1));
  assign last       = (bit_q == 4'(NB - 1));
  assign frame_done = tick && last;
  assign ready      = !act_q;
  assign txd        = txd_q;

  // Bit timing and shift sequencing.
  always_comb begin
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    txd_d = txd_q;
    act_d = act_q;
    if (load && !act_q) begin
      txd_d = frame[0];
      sh_d  = frame >> 1;
      cnt_d = '0;
      bit_d = '0;
      act_d = 1'b1;
    end else if (act_q) begin
      if (tick) begin
        cnt_d = '0;
        if (last) begin
          act_d = 1'b0;
          txd_d = 1'b1;
        end else begin
          txd_d = sh_q[0];
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers; reset returns the line to idle high at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '1;
      txd_q <= 1'b1;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
      txd_q <= txd_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/uart_tx_dma_burst.sv
// DMA burst UART transmitter: fetch bytes from memory, send as frames.
// Start/busy/done handshake, abort at frame boundary, live remain count.
module uart_tx_dma_burst
  import uart_pkg::*;
#(
  parameter int Clock  = 50000000,
  parameter int Baud   = 9600,
  parameter int Stop   = 1,
  parameter int Parity = 0,
  parameter int AddrW  = 16,
  parameter int LenW   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [AddrW-1:0]    base,
  input  logic [LenW-1:0]     leng,
  uart_tx_dma_burst_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LenW-1:0]     remain,
  output logic                txd
);

  dma_state_t       state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic [LenW-1:0]  remain_q, remain_d;
  logic [LenW-1:0]  rem_dec;
  logic [7:0]       hold_q, hold_d;
  logic             aborted_q, aborted_d;
  logic             load;
  logic             frame_done;
  logic             ser_ready;

  uart_tx_serializer #(
    .Clock  (Clock),
    .Baud   (Baud),
    .Stop   (Stop),
    .Parity (Parity)
  ) u_ser (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .data       (hold_q),
    .txd        (txd),
    .frame_done (frame_done),
    .ready      (ser_ready)
  );

  assign rem_dec     = remain_q - LenW'(1);
  assign bus.rd_en   = (state_q == FETCH);
  assign bus.rd_addr = ptr_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign aborted     = aborted_q;
  assign remain      = remain_q;

  // Transfer sequencing: one fetch/wait/load/send round per byte.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    hold_d    = hold_q;
    aborted_d = aborted_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d     = base;
          remain_d  = leng;
          aborted_d = 1'b0;
          state_d   = (leng == '0) ? FIN : FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        hold_d  = bus.rd_data;
        state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        ptr_d   = ptr_q + AddrW'(1);
        state_d = SEND;
      end
      SEND: begin
        if (frame_done) begin
          if (remain_q != '0) remain_d = rem_dec;
          if (remain_q == '0 || rem_dec == '0) begin
            state_d = FIN;
          end else if (abort) begin
            aborted_d = 1'b1;
            state_d   = FIN;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      remain_q  <= '0;
      hold_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      remain_q  <= remain_d;
      hold_q    <= hold_d;
      aborted_q <= aborted_d;
    end
  end

  // Memory strobe only ever comes from the fetch state.
  a_rd_en_fetch: assert property (@(posedge clock) disable iff (reset)
    bus.rd_en |-> (state_q == FETCH));

  // The serializer is always idle when a byte is handed over.
  a_load_ready: assert property (@(posedge clock) disable iff (reset)
    (state_q == LOAD) |-> ser_ready);

endmodule

// File: tb/tb_uart_tx_dma_burst.sv
// Directed bench for uart_tx_dma_burst (Clock=1000, Baud=100, DIV=10).
// Three instances: default, 8-bit address, odd parity with 2 stop bits.
module tb_uart_tx_dma_burst;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       start = '0;
  logic [2:0]       abort = '0;
  logic [2:0]       busy, done, aborted, txd;
  logic [15:0]      base = '0;
  logic [15:0]      leng = '0;
  logic [2:0][15:0] rem;

  logic [7:0] mem [256];

  uart_tx_dma_burst_if #(.AddrW(16)) m0 ();
  uart_tx_dma_burst_if #(.AddrW(8))  m1 ();
  uart_tx_dma_burst_if #(.AddrW(16)) m2 ();

  uart_tx_dma_burst #(
    .Clock(1000), .Baud(100), .Stop(1), .Parity(0), .AddrW(16), .LenW(16)
  ) u0 (
    .clock(clk), .reset(rst), .start(start[0]), .abort(abort[0]),
    .base(base), .leng(leng), .bus(m0), .busy(busy[0]), .done(done[0]),
    .aborted(aborted[0]), .remain(rem[0]), .txd(txd[0])
  );

  uart_tx_dma_burst #(
    .Clock(1000), .Baud(100), .Stop(1), .Parity(0), .AddrW(8), .LenW(16)
  ) u1 (
    .clock(clk), .reset(rst), .start(start[1]), .abort(abort[1]),
    .base(base[7:0]), .leng(leng), .bus(m1), .busy(busy[1]), .done(done[1]),
    .aborted(aborted[1]), .remain(rem[1]), .txd(txd[1])
  );

  uart_tx_dma_burst #(
    .Clock(1000), .Baud(100), .Stop(2), .Parity(2), .AddrW(16), .LenW(16)
  ) u2 (
    .clock(clk), .reset(rst), .start(start[2]), .abort(abort[2]),
    .base(base), .leng(leng), .bus(m2), .busy(busy[2]), .done(done[2]),
    .aborted(aborted[2]), .remain(rem[2]), .txd(txd[2])
  );

  // Synchronous memory model, one read port per instance.
  always @(posedge clk) begin
    if (m0.rd_en) m0.rd_data <= mem[m0.rd_addr[7:0]];
    if (m1.rd_en) m1.rd_data <= mem[m1.rd_addr];
    if (m2.rd_en) m2.rd_data <= mem[m2.rd_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         ndone [3] = '{0, 0, 0};
  int         tdone [3] = '{0, 0, 0};
  logic [2:0] ab_at_done = '0;
  int         nrd0 = 0;
  int         nbusy0 = 0;
  int         ntxl0 = 0;
  logic [7:0] alog [$];

  // Event monitor, sampling pre-edge values.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        ndone[i]++;
        tdone[i] = cyc;
        ab_at_done[i] = aborted[i];
      end
    end
    if (m0.rd_en) nrd0++;
    if (busy[0]) nbusy0++;
    if (!txd[0]) ntxl0++;
    if (m1.rd_en) alog.push_back(m1.rd_addr);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic go(input int sel, input logic [15:0] b,
                    input logic [15:0] l, output int c0);
    @(negedge clk);
    base = b;
    leng = l;
    start[sel] = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  task automatic wait_fall(input int sel, input int budget,
                           input string tag, output int s);
    logic ok;
    ok = 1'b0;
    s = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!txd[sel]) begin
        ok = 1'b1;
        s = cyc;
        break;
      end
    end
    check(tag, 32'(ok), 1);
  endtask

  // Called at the detection edge; samples each bit at its centre.
  task automatic rx_bits(input int sel, input int nb,
                         output logic [15:0] bits);
    bits = '0;
    repeat (5) @(negedge clk);
    bits[0] = txd[sel];
    for (int i = 1; i < nb; i++) begin
      repeat (10) @(negedge clk);
      bits[i] = txd[sel];
    end
  endtask

  task automatic wait_done(input int sel, input int n0, input int budget,
                           input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ndone[sel] > n0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench watchdog");
  end

  initial begin
    int c0, s1, s2, s3, n0, r0, b0, t0;
    logic [15:0] bits;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h55; mem[8'h11] = 8'hA3; mem[8'h12] = 8'hFF;
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02;
    mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;
    mem[8'h20] = 8'h07;
    for (int i = 0; i < 5; i++) mem[8'h30 + i] = 8'h5A;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd[0]), 1);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_aborted", 32'(aborted[0]), 0);
    check("rst_rd_en", 32'(m0.rd_en), 0);
    check("rst_rd_addr", 32'(m0.rd_addr), 0);
    check("rst_remain", 32'(rem[0]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: three back-to-back frames.
    n0 = ndone[0];
    go(0, 16'h0010, 16'd3, c0);
    wait_fall(0, 20, "t1_f1_seen", s1);
    check("t1_latency", 32'(s1 - c0), 4);
    check("t1_rem_f1", 32'(rem[0]), 3);
    rx_bits(0, 10, bits);
    check("t1_frame1", 32'(bits), 32'h2AA);
    wait_fall(0, 30, "t1_f2_seen", s2);
    check("t1_gap12", 32'(s2 - s1), 103);
    check("t1_rem_f2", 32'(rem[0]), 2);
    rx_bits(0, 10, bits);
    check("t1_frame2", 32'(bits), 32'h346);
    wait_fall(0, 30, "t1_f3_seen", s3);
    check("t1_gap23", 32'(s3 - s2), 103);
    check("t1_rem_f3", 32'(rem[0]), 1);
    rx_bits(0, 10, bits);
    check("t1_frame3", 32'(bits), 32'h3FE);
    wait_done(0, n0, 40, "t1_done_seen");
    check("t1_done_time", 32'(tdone[0] - s3), 100);
    check("t1_rem_end", 32'(rem[0]), 0);
    repeat (3) @(negedge clk);
    check("t1_done_once", 32'(ndone[0] - n0), 1);
    check("t1_not_aborted", 32'(ab_at_done[0]), 0);

    // 4: abort held from mid frame 2 stops after that frame.
    n0 = ndone[0];
    r0 = nrd0;
    go(0, 16'h0030, 16'd5, c0);
    wait_fall(0, 20, "t4_f1_seen", s1);
    repeat (153) @(negedge clk);
    abort[0] = 1'b1;
    wait_done(0, n0, 200, "t4_done_seen");
    abort[0] = 1'b0;
    check("t4_aborted", 32'(ab_at_done[0]), 1);
    check("t4_remain", 32'(rem[0]), 3);
    check("t4_reads", 32'(nrd0 - r0), 2);
    repeat (5) @(negedge clk);
    check("t4_aborted_hold", 32'(aborted[0]), 1);

    // 2: empty transfer.
    n0 = ndone[0];
    r0 = nrd0;
    b0 = nbusy0;
    t0 = ntxl0;
    go(0, 16'h0010, 16'd0, c0);
    wait_done(0, n0, 10, "t2_done_seen");
    repeat (5) @(negedge clk);
    check("t2_done_time", 32'(tdone[0] - c0), 1);
    check("t2_no_reads", 32'(nrd0 - r0), 0);
    check("t2_txd_high", 32'(ntxl0 - t0), 0);
    check("t2_busy_cycles", 32'(nbusy0 - b0), 1);
    check("t2_abort_clr", 32'(ab_at_done[0]), 0);

    // 3: 8-bit address wraps.
    alog.delete();
    n0 = ndone[1];
    go(1, 16'h00FE, 16'd4, c0);
    wait_done(1, n0, 600, "t3_done_seen");
    check("t3_nreads", 32'(alog.size()), 4);
    if (alog.size() == 4) begin
      check("t3_addr0", 32'(alog[0]), 32'hFE);
      check("t3_addr1", 32'(alog[1]), 32'hFF);
      check("t3_addr2", 32'(alog[2]), 32'h00);
      check("t3_addr3", 32'(alog[3]), 32'h01);
    end

    // 5: odd parity, two stop bits.
    n0 = ndone[2];
    go(2, 16'h0020, 16'd1, c0);
    wait_fall(2, 20, "t5_f_seen", s1);
    rx_bits(2, 12, bits);
    check("t5_frame", 32'(bits), 32'hC0E);
    wait_done(2, n0, 60, "t5_done_seen");
    check("t5_frame_len", 32'(tdone[2] - s1), 120);

    // 6: reset mid data bit, then a clean frame.
    go(0, 16'h0010, 16'd1, c0);
    wait_fall(0, 20, "t6_f_seen", s1);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_txd", 32'(txd[0]), 1);
    check("t6_busy", 32'(busy[0]), 0);
    check("t6_remain", 32'(rem[0]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n0 = ndone[0];
    go(0, 16'h0011, 16'd1, c0);
    wait_fall(0, 20, "t6_f2_seen", s1);
    check("t6_latency", 32'(s1 - c0), 4);
    rx_bits(0, 10, bits);
    check("t6_frame", 32'(bits), 32'h346);
    wait_done(0, n0, 40, "t6_done_seen");
    check("t6_not_aborted", 32'(ab_at_done[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
